// File: rtl/halloween_show_sequencer.sv
// Triggered four-slot show sequencer: steps a latched opcode program with a
// programmable dwell per step and drives registered color, sound and effect.
module halloween_show_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               on_i,
  input  logic [15:0]        prog_data_i,
  input  logic               prog_load_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               trig_i,
  output logic               busy_o,
  output logic [1:0]         slot_o,
  output logic [1:0]         color_o,
  output logic [2:0]         sound_o,
  output logic [2:0]         effect_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [2:0] {IDLE, ARMED, ISSUE, HOLD, DONE} state_e;

  typedef struct packed {
    logic       setColor;
    logic [1:0] color;
    logic [2:0] sound;
    logic [2:0] effect;
    logic       isReset;
    logic       illegal;
  } decode_t;

  localparam logic [3:0] OP_ON     = 4'b0000;
  localparam logic [3:0] OP_RESET  = 4'b0001;
  localparam logic [3:0] OP_GREEN  = 4'b0100;
  localparam logic [3:0] OP_PURPLE = 4'b0101;
  localparam logic [3:0] OP_ORANGE = 4'b0110;
  localparam logic [3:0] OP_SCREAM = 4'b1000;
  localparam logic [3:0] OP_CACKLE = 4'b1001;
  localparam logic [3:0] OP_BOO    = 4'b1010;
  localparam logic [3:0] OP_HANDS  = 4'b1100;
  localparam logic [3:0] OP_JAW    = 4'b1101;
  localparam logic [3:0] OP_FOG    = 4'b1110;

  // Effect field stays zero for every non-effect op, which is what clears it.
  function automatic decode_t decodeOp(input logic [3:0] op);
    decode_t d;
    d = '0;
    case (op)
      OP_ON:     d = '0;
      OP_RESET:  d.isReset = 1'b1;
      OP_GREEN:  begin d.setColor = 1'b1; d.color = 2'b01; end
      OP_PURPLE: begin d.setColor = 1'b1; d.color = 2'b10; end
      OP_ORANGE: begin d.setColor = 1'b1; d.color = 2'b11; end
      OP_SCREAM: d.sound = 3'b001;
      OP_CACKLE: d.sound = 3'b010;
      OP_BOO:    d.sound = 3'b100;
      OP_HANDS:  d.effect = 3'b001;
      OP_JAW:    d.effect = 3'b010;
      OP_FOG:    d.effect = 3'b100;
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  state_e               state_q, state_d;
  logic [15:0]          prog_q, prog_d;
  logic [1:0]           slot_q, slot_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           color_q, color_d;
  logic [2:0]           sound_q, sound_d;
  logic [2:0]           effect_q, effect_d;
  logic                 err_q, err_d;

  logic [3:0]           curOp;
  decode_t              opDec;
  logic                 progEmpty;
  logic                 loadOk;
  logic                 startRun;
  logic                 lastStep;

  assign curOp     = prog_q[{slot_q, 2'b00} +: 4];
  assign opDec     = decodeOp(curOp);
  assign progEmpty = (prog_q == '0);
  assign loadOk    = prog_load_i && ((state_q == IDLE) || (state_q == ARMED));
  // A load in the same cycle as a trigger takes priority and drops the trigger.
  assign startRun  = on_i && (state_q == ARMED) && trig_i && !prog_load_i && !progEmpty;
  assign lastStep  = (slot_q == 2'd3) || opDec.isReset;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!on_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (startRun) state_d = ISSUE;
        ISSUE:   state_d = HOLD;
        HOLD:    if (cnt_q == '0) state_d = lastStep ? DONE : ISSUE;
        DONE:    state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    prog_d   = loadOk ? prog_data_i : prog_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    color_d  = color_q;
    sound_d  = '0;
    effect_d = effect_q;
    err_d    = err_q;
    if (!on_i) begin
      slot_d   = '0;
      cnt_d    = '0;
      color_d  = '0;
      effect_d = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (startRun) slot_d = '0;
        end
        ISSUE: begin
          cnt_d    = dwell_i;
          sound_d  = opDec.sound;
          effect_d = opDec.effect;
          if (opDec.setColor) color_d = opDec.color;
          if (opDec.isReset) color_d = '0;
          if (opDec.illegal) err_d = 1'b1;
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (!lastStep) begin
            slot_d = slot_q + 2'd1;
          end
        end
        DONE: begin
          color_d  = '0;
          effect_d = '0;
        end
        default: begin
          slot_d = slot_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      prog_q   <= '0;
      slot_q   <= '0;
      cnt_q    <= '0;
      color_q  <= '0;
      sound_q  <= '0;
      effect_q <= '0;
      err_q    <= 1'b0;
    end else begin
      prog_q   <= prog_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      color_q  <= color_d;
      sound_q  <= sound_d;
      effect_q <= effect_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    busy_o   = (state_q == ISSUE) || (state_q == HOLD) || (state_q == DONE);
    done_o   = (state_q == DONE);
    slot_o   = slot_q;
    color_o  = color_q;
    sound_o  = sound_q;
    effect_o = effect_q;
    err_o    = err_q;
  end

endmodule

// File: tb/tb_halloween_show_sequencer.sv
// Scoreboard bench: stimulus queues the expected output changes with their
// cycle numbers; a negedge monitor pops one entry per observed output change.
module tb_halloween_show_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        on;
  logic        progLoad;
  logic        trig;
  logic [15:0] progData;
  logic [7:0]  dwell;
  logic        busy;
  logic [1:0]  slot;
  logic [1:0]  color;
  logic [2:0]  sound;
  logic [2:0]  effect;
  logic        done;
  logic        err;

  typedef struct packed {
    logic       busy;
    logic [1:0] slot;
    logic [1:0] color;
    logic [2:0] sound;
    logic [2:0] effect;
    logic       done;
    logic       err;
  } obs_t;

  int    checks   = 0;
  int    failures = 0;
  int    edgeCnt  = 0;
  int    t;
  int    expCyc[$];
  obs_t  expObs[$];
  string expTag[$];
  obs_t  prevObs;
  obs_t  curObs;
  bit    prevValid  = 1'b0;
  bit    finalCheck = 1'b0;
  bit    monDone    = 1'b0;

  halloween_show_sequencer #(.DWELL_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .on_i       (on),
    .prog_data_i(progData),
    .prog_load_i(progLoad),
    .dwell_i    (dwell),
    .trig_i     (trig),
    .busy_o     (busy),
    .slot_o     (slot),
    .color_o    (color),
    .sound_o    (sound),
    .effect_o   (effect),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt++;

  function automatic string obsStr(input obs_t o);
    return $sformatf("busy=%b slot=%0d color=%b sound=%b effect=%b done=%b err=%b",
                     o.busy, o.slot, o.color, o.sound, o.effect, o.done, o.err);
  endfunction

  task automatic checkOutput(input string tag, input int reqCyc, input obs_t reqObs,
                             input obs_t gotObs, input bit expected);
    checks++;
    if (!expected) begin
      failures++;
      $display("[TB] FAIL %s: got cycle=%0d %s, required no output change",
               tag, edgeCnt, obsStr(gotObs));
    end else if (reqCyc != edgeCnt || gotObs !== reqObs) begin
      failures++;
      $display("[TB] FAIL %s: got cycle=%0d %s, required cycle=%0d %s",
               tag, edgeCnt, obsStr(gotObs), reqCyc, obsStr(reqObs));
    end
  endtask

  task automatic expectEvt(input int cyc, input logic b, input logic [1:0] s,
                           input logic [1:0] c, input logic [2:0] snd,
                           input logic [2:0] eff, input logic d, input logic e,
                           input string tag);
    obs_t o;
    o = {b, s, c, snd, eff, d, e};
    expCyc.push_back(cyc);
    expObs.push_back(o);
    expTag.push_back(tag);
  endtask

  task automatic applyStimulus(input logic onV, input logic loadV, input logic trigV,
                               input logic [15:0] progV, input logic [7:0] dwellV);
    on       = onV;
    progLoad = loadV;
    trig     = trigV;
    progData = progV;
    dwell    = dwellV;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Every change of the output tuple must match the head of the expectation queue.
  always @(negedge clk) begin
    curObs = {busy, slot, color, sound, effect, done, err};
    if (!monDone) begin
      if (!prevValid || curObs !== prevObs) begin
        if (expCyc.size() == 0)
          checkOutput("unexpected_event", 0, '0, curObs, 1'b0);
        else
          checkOutput(expTag.pop_front(), expCyc.pop_front(), expObs.pop_front(), curObs, 1'b1);
      end
      if (finalCheck) begin
        checks++;
        if (expCyc.size() != 0) begin
          failures++;
          $display("[TB] FAIL pending_events: got %0d outstanding, required 0 (next %s at cycle %0d)",
                   expCyc.size(), expTag[0], expCyc[0]);
        end
        monDone = 1'b1;
      end
    end
    prevObs   = curObs;
    prevValid = 1'b1;
  end

  initial begin
    // Reset held with on and trig high; nothing may start afterwards on the empty program.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 8'd0);
    expectEvt(1, 0, 0, 0, 0, 0, 0, 0, "reset_state");
    stepEdges(2);
    rst = 1'b1;
    stepEdges(4);

    // Full four-slot run, dwell 3: green, orange, cackle, fog.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hE964, 8'd3);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hE964, 8'd3);
    t = edgeCnt + 1;
    expectEvt(t,      1, 0, 2'b00, 3'b000, 3'b000, 0, 0, "full_issue0");
    expectEvt(t + 1,  1, 0, 2'b01, 3'b000, 3'b000, 0, 0, "full_green");
    expectEvt(t + 5,  1, 1, 2'b01, 3'b000, 3'b000, 0, 0, "full_issue1");
    expectEvt(t + 6,  1, 1, 2'b11, 3'b000, 3'b000, 0, 0, "full_orange");
    expectEvt(t + 10, 1, 2, 2'b11, 3'b000, 3'b000, 0, 0, "full_issue2");
    expectEvt(t + 11, 1, 2, 2'b11, 3'b010, 3'b000, 0, 0, "full_cackle");
    expectEvt(t + 12, 1, 2, 2'b11, 3'b000, 3'b000, 0, 0, "full_cackle_end");
    expectEvt(t + 15, 1, 3, 2'b11, 3'b000, 3'b000, 0, 0, "full_issue3");
    expectEvt(t + 16, 1, 3, 2'b11, 3'b000, 3'b100, 0, 0, "full_fog");
    expectEvt(t + 20, 1, 3, 2'b11, 3'b000, 3'b100, 1, 0, "full_done");
    expectEvt(t + 21, 0, 3, 2'b00, 3'b000, 3'b000, 0, 0, "full_armed");
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hE964, 8'd3);
    stepEdges(22);

    // RESET opcode in slot 2 ends the run early, dwell 0.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h5140, 8'd0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h5140, 8'd0);
    t = edgeCnt + 1;
    expectEvt(t,     1, 0, 2'b00, 3'b000, 3'b000, 0, 0, "rst_issue0");
    expectEvt(t + 2, 1, 1, 2'b00, 3'b000, 3'b000, 0, 0, "rst_issue1");
    expectEvt(t + 3, 1, 1, 2'b01, 3'b000, 3'b000, 0, 0, "rst_green");
    expectEvt(t + 4, 1, 2, 2'b01, 3'b000, 3'b000, 0, 0, "rst_issue2");
    expectEvt(t + 5, 1, 2, 2'b00, 3'b000, 3'b000, 0, 0, "rst_clear");
    expectEvt(t + 6, 1, 2, 2'b00, 3'b000, 3'b000, 1, 0, "rst_done");
    expectEvt(t + 7, 0, 2, 2'b00, 3'b000, 3'b000, 0, 0, "rst_armed");
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h5140, 8'd0);
    stepEdges(10);

    // Illegal opcode in slot 2; trig held high gives a back-to-back second run.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0B00, 8'd0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0B00, 8'd0);
    t = edgeCnt + 1;
    expectEvt(t,      1, 0, 2'b00, 3'b000, 3'b000, 0, 0, "ill_issue0");
    expectEvt(t + 2,  1, 1, 2'b00, 3'b000, 3'b000, 0, 0, "ill_issue1");
    expectEvt(t + 4,  1, 2, 2'b00, 3'b000, 3'b000, 0, 0, "ill_issue2");
    expectEvt(t + 5,  1, 2, 2'b00, 3'b000, 3'b000, 0, 1, "ill_err_set");
    expectEvt(t + 6,  1, 3, 2'b00, 3'b000, 3'b000, 0, 1, "ill_issue3");
    expectEvt(t + 8,  1, 3, 2'b00, 3'b000, 3'b000, 1, 1, "ill_done");
    expectEvt(t + 9,  0, 3, 2'b00, 3'b000, 3'b000, 0, 1, "ill_armed_gap");
    expectEvt(t + 10, 1, 0, 2'b00, 3'b000, 3'b000, 0, 1, "ill2_issue0");
    expectEvt(t + 12, 1, 1, 2'b00, 3'b000, 3'b000, 0, 1, "ill2_issue1");
    expectEvt(t + 14, 1, 2, 2'b00, 3'b000, 3'b000, 0, 1, "ill2_issue2");
    expectEvt(t + 16, 1, 3, 2'b00, 3'b000, 3'b000, 0, 1, "ill2_issue3");
    expectEvt(t + 18, 1, 3, 2'b00, 3'b000, 3'b000, 1, 1, "ill2_done");
    expectEvt(t + 19, 0, 3, 2'b00, 3'b000, 3'b000, 0, 1, "ill2_armed");
    stepEdges(11);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0B00, 8'd0);
    stepEdges(12);

    // Abort during slot 1 hold; the load attempted mid-run must not take.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h04C5, 8'd3);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h04C5, 8'd3);
    t = edgeCnt + 1;
    expectEvt(t,     1, 0, 2'b00, 3'b000, 3'b000, 0, 1, "abt_issue0");
    expectEvt(t + 1, 1, 0, 2'b10, 3'b000, 3'b000, 0, 1, "abt_purple");
    expectEvt(t + 5, 1, 1, 2'b10, 3'b000, 3'b000, 0, 1, "abt_issue1");
    expectEvt(t + 6, 1, 1, 2'b10, 3'b000, 3'b001, 0, 1, "abt_hands");
    expectEvt(t + 8, 0, 0, 2'b00, 3'b000, 3'b000, 0, 1, "abt_idle");
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h04C5, 8'd3);
    stepEdges(6);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0006, 8'd3);
    stepEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0006, 8'd0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0006, 8'd0);
    stepEdges(1);
    t = edgeCnt + 1;
    expectEvt(t,     1, 0, 2'b00, 3'b000, 3'b000, 0, 1, "rdb_issue0");
    expectEvt(t + 1, 1, 0, 2'b10, 3'b000, 3'b000, 0, 1, "rdb_purple");
    expectEvt(t + 2, 1, 1, 2'b10, 3'b000, 3'b000, 0, 1, "rdb_issue1");
    expectEvt(t + 3, 1, 1, 2'b10, 3'b000, 3'b001, 0, 1, "rdb_hands");
    expectEvt(t + 4, 1, 2, 2'b10, 3'b000, 3'b001, 0, 1, "rdb_issue2");
    expectEvt(t + 5, 1, 2, 2'b01, 3'b000, 3'b000, 0, 1, "rdb_green");
    expectEvt(t + 6, 1, 3, 2'b01, 3'b000, 3'b000, 0, 1, "rdb_issue3");
    expectEvt(t + 8, 1, 3, 2'b01, 3'b000, 3'b000, 1, 1, "rdb_done");
    expectEvt(t + 9, 0, 3, 2'b00, 3'b000, 3'b000, 0, 1, "rdb_armed");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0006, 8'd0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0006, 8'd0);
    stepEdges(12);

    // Load and trig together: load wins, no run until a later trig.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0004, 8'd0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0004, 8'd0);
    stepEdges(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0004, 8'd0);
    t = edgeCnt + 1;
    expectEvt(t,     1, 0, 2'b00, 3'b000, 3'b000, 0, 1, "cont_issue0");
    expectEvt(t + 1, 1, 0, 2'b01, 3'b000, 3'b000, 0, 1, "cont_green");
    expectEvt(t + 2, 1, 1, 2'b01, 3'b000, 3'b000, 0, 1, "cont_issue1");
    expectEvt(t + 4, 1, 2, 2'b01, 3'b000, 3'b000, 0, 1, "cont_issue2");
    expectEvt(t + 6, 1, 3, 2'b01, 3'b000, 3'b000, 0, 1, "cont_issue3");
    expectEvt(t + 8, 1, 3, 2'b01, 3'b000, 3'b000, 1, 1, "cont_done");
    expectEvt(t + 9, 0, 3, 2'b00, 3'b000, 3'b000, 0, 1, "cont_armed");
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0004, 8'd0);
    stepEdges(11);

    // Emptied program: a held trig must not start anything.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 8'd0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 8'd0);
    stepEdges(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'd0);
    stepEdges(2);

    finalCheck = 1'b1;
    stepEdges(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
